// File: rtl/hash_table_ctrl_if.sv
// Request/response and hash-unit handshake bundle for hash_table_ctrl.
// The controller uses the slave modport; the requester/hash side uses master.
interface hash_table_ctrl_if #(
   parameter int unsigned INDEX_W  = 8,
   parameter int unsigned ACTION_W = 32
);
   logic                req_valid_i;
   logic                req_ready_o;
   logic [1:0]          req_op_i;
   logic [63:0]         req_key_i;
   logic [ACTION_W-1:0] req_action_i;
   logic                hash_start_o;
   logic [63:0]         hash_key_o;
   logic                hash_ready_i;
   logic [31:0]         hash_val_i;
   logic                resp_valid_o;
   logic                resp_hit_o;
   logic [1:0]          resp_status_o;
   logic [ACTION_W-1:0] resp_action_o;
   logic [INDEX_W-1:0]  resp_index_o;

   modport slave (
      input  req_valid_i, req_op_i, req_key_i, req_action_i, hash_ready_i, hash_val_i,
      output req_ready_o, hash_start_o, hash_key_o,
      output resp_valid_o, resp_hit_o, resp_status_o, resp_action_o, resp_index_o
   );

   modport master (
      output req_valid_i, req_op_i, req_key_i, req_action_i, hash_ready_i, hash_val_i,
      input  req_ready_o, hash_start_o, hash_key_o,
      input  resp_valid_o, resp_hit_o, resp_status_o, resp_action_o, resp_index_o
   );
endinterface

// File: rtl/hash_table_ctrl.sv
// Exact-match table engine: hash-indexed bucket array with bounded linear probing.
// Optional statistics counters are enabled with the HASH_TABLE_STATS_EN macro.
module hash_table_ctrl #(
   parameter int unsigned INDEX_W     = 8,
   parameter int unsigned PROBE_LIMIT = 4,
   parameter int unsigned ACTION_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   hash_table_ctrl_if.slave    bus
`ifdef HASH_TABLE_STATS_EN
   ,
   output logic [31:0]         stat_lookup_o,
   output logic [31:0]         stat_hit_o,
   output logic [31:0]         stat_full_o
`endif
);
   localparam int unsigned DEPTH = 2 ** INDEX_W;
   localparam int unsigned PW    = $clog2(PROBE_LIMIT + 1);

   localparam logic [1:0] OP_LOOKUP = 2'd0;
   localparam logic [1:0] OP_INSERT = 2'd1;
   localparam logic [1:0] OP_DELETE = 2'd2;
   localparam logic [1:0] ST_OK     = 2'd0;
   localparam logic [1:0] ST_NF     = 2'd1;
   localparam logic [1:0] ST_FULL   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ARM, S_WAIT, S_READ, S_CMP, S_RESP
   } state_t;

   state_t              state_q;
   logic [DEPTH-1:0]    valid_q;
   logic [63:0]         key_mem [DEPTH];
   logic [ACTION_W-1:0] act_mem [DEPTH];

   logic [1:0]          op_q;
   logic [63:0]         key_q;
   logic [ACTION_W-1:0] act_q;
   logic [INDEX_W-1:0]  idx_q;
   logic [PW-1:0]       probe_q;
   logic                free_vld_q;
   logic [INDEX_W-1:0]  free_idx_q;
   logic                rd_valid_q;
   logic [63:0]         rd_key_q;
   logic [ACTION_W-1:0] rd_act_q;

   logic                req_ready_q;
   logic                hash_start_q;
   logic [63:0]         hash_key_q;
   logic                resp_valid_q;
   logic                resp_hit_q;
   logic [1:0]          resp_status_q;
   logic [ACTION_W-1:0] resp_action_q;
   logic [INDEX_W-1:0]  resp_index_q;
`ifdef HASH_TABLE_STATS_EN
   logic [31:0]         stat_lookup_q;
   logic [31:0]         stat_hit_q;
   logic [31:0]         stat_full_q;
`endif

   logic                match_s;
   logic                last_s;
   logic                free_avail_s;
   logic [INDEX_W-1:0]  free_sel_s;
   logic                mem_we_s;
   logic [INDEX_W-1:0]  mem_wr_idx_s;
   logic                unused_hash_s;

   assign unused_hash_s = ^bus.hash_val_i[31:INDEX_W];

   // Probe evaluation and table write control for the CMP cycle
   always_comb begin
      match_s      = rd_valid_q && (rd_key_q == key_q);
      last_s       = (probe_q == PW'(PROBE_LIMIT - 1));
      // The slot under examination counts as free on the last probe as well
      free_avail_s = free_vld_q || !rd_valid_q;
      free_sel_s   = free_vld_q ? free_idx_q : idx_q;
      mem_we_s     = 1'b0;
      mem_wr_idx_s = idx_q;
      if ((state_q == S_CMP) && (op_q == OP_INSERT)) begin
         if (match_s) begin
            mem_we_s = 1'b1;
         end else if (last_s && free_avail_s) begin
            mem_we_s     = 1'b1;
            mem_wr_idx_s = free_sel_s;
         end else begin
            mem_we_s = 1'b0;
         end
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Key/action storage: written only on INSERT resolution, read in READ
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         key_mem[mem_wr_idx_s] <= key_q;
         act_mem[mem_wr_idx_s] <= act_q;
      end
      if (state_q == S_READ) begin
         rd_key_q <= key_mem[idx_q];
         rd_act_q <= act_mem[idx_q];
      end
   end

   // Control FSM with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         valid_q       <= '0;
         op_q          <= OP_LOOKUP;
         key_q         <= 64'd0;
         act_q         <= '0;
         idx_q         <= '0;
         probe_q       <= '0;
         free_vld_q    <= 1'b0;
         free_idx_q    <= '0;
         rd_valid_q    <= 1'b0;
         req_ready_q   <= 1'b1;
         hash_start_q  <= 1'b0;
         hash_key_q    <= 64'd0;
         resp_valid_q  <= 1'b0;
         resp_hit_q    <= 1'b0;
         resp_status_q <= ST_OK;
         resp_action_q <= '0;
         resp_index_q  <= '0;
`ifdef HASH_TABLE_STATS_EN
         stat_lookup_q <= 32'd0;
         stat_hit_q    <= 32'd0;
         stat_full_q   <= 32'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid_i) begin
                  op_q         <= (bus.req_op_i == 2'd3) ? OP_LOOKUP : bus.req_op_i;
                  key_q        <= bus.req_key_i;
                  act_q        <= bus.req_action_i;
                  hash_key_q   <= bus.req_key_i;
                  req_ready_q  <= 1'b0;
                  hash_start_q <= 1'b1;
                  state_q      <= S_START;
               end
            end
            S_START: begin
               hash_start_q <= 1'b0;
               state_q      <= S_ARM;
            end
            S_ARM: state_q <= S_WAIT;
            S_WAIT: begin
               if (bus.hash_ready_i) begin
                  idx_q      <= bus.hash_val_i[INDEX_W-1:0];
                  probe_q    <= '0;
                  free_vld_q <= 1'b0;
                  state_q    <= S_READ;
               end
            end
            S_READ: begin
               rd_valid_q <= valid_q[idx_q];
               state_q    <= S_CMP;
            end
            S_CMP: begin
               if (match_s) begin
                  resp_valid_q  <= 1'b1;
                  resp_hit_q    <= 1'b1;
                  resp_status_q <= ST_OK;
                  resp_index_q  <= idx_q;
                  state_q       <= S_RESP;
                  case (op_q)
                     OP_INSERT: resp_action_q <= act_q;
                     OP_DELETE: begin
                        resp_action_q  <= '0;
                        valid_q[idx_q] <= 1'b0;
                     end
                     default: resp_action_q <= rd_act_q;
                  endcase
`ifdef HASH_TABLE_STATS_EN
                  if (op_q == OP_LOOKUP) begin
                     stat_lookup_q <= stat_lookup_q + 32'd1;
                     stat_hit_q    <= stat_hit_q + 32'd1;
                  end
`endif
               end else if (!last_s) begin
                  if ((op_q == OP_INSERT) && !rd_valid_q && !free_vld_q) begin
                     free_vld_q <= 1'b1;
                     free_idx_q <= idx_q;
                  end
                  idx_q   <= idx_q + INDEX_W'(1);
                  probe_q <= probe_q + PW'(1);
                  state_q <= S_READ;
               end else begin
                  resp_valid_q  <= 1'b1;
                  resp_hit_q    <= 1'b0;
                  resp_action_q <= '0;
                  state_q       <= S_RESP;
                  if ((op_q == OP_INSERT) && free_avail_s) begin
                     resp_status_q       <= ST_OK;
                     resp_index_q        <= free_sel_s;
                     valid_q[free_sel_s] <= 1'b1;
                  end else begin
                     resp_status_q <= (op_q == OP_INSERT) ? ST_FULL : ST_NF;
                     resp_index_q  <= '0;
                  end
`ifdef HASH_TABLE_STATS_EN
                  if (op_q == OP_LOOKUP) stat_lookup_q <= stat_lookup_q + 32'd1;
                  if ((op_q == OP_INSERT) && !free_avail_s) stat_full_q <= stat_full_q + 32'd1;
`endif
               end
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o   = req_ready_q;
   assign bus.hash_start_o  = hash_start_q;
   assign bus.hash_key_o    = hash_key_q;
   assign bus.resp_valid_o  = resp_valid_q;
   assign bus.resp_hit_o    = resp_hit_q;
   assign bus.resp_status_o = resp_status_q;
   assign bus.resp_action_o = resp_action_q;
   assign bus.resp_index_o  = resp_index_q;
`ifdef HASH_TABLE_STATS_EN
   assign stat_lookup_o = stat_lookup_q;
   assign stat_hit_o    = stat_hit_q;
   assign stat_full_o   = stat_full_q;
`endif
endmodule

// File: tb/tb_hash_table_ctrl.sv
// Directed self-checking bench for hash_table_ctrl; the hash unit is modelled
// as a byte-sum of the key, ready three cycles after the start pulse.
module tb_hash_table_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   // captured response of the last request
   int          r_lat;
   int          r_seen;
   int          r_rdy_viol;
   int          r_starts;
   logic [1:0]  r_status;
   logic        r_hit;
   logic [31:0] r_act;
   logic [7:0]  r_idx;
   int          hcnt = 0;

   always #5 clk = ~clk;

   hash_table_ctrl_if #(.INDEX_W(8), .ACTION_W(32)) bus ();

   hash_table_ctrl #(.INDEX_W(8), .PROBE_LIMIT(4), .ACTION_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] byte_sum(input logic [63:0] k);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < 8; i++) s = s + {24'd0, k[8*i +: 8]};
      return s;
   endfunction

   // hash unit model
   initial begin
      bus.hash_ready_i = 1'b0;
      bus.hash_val_i   = 32'd0;
      forever begin
         @(negedge clk);
         if (bus.hash_start_o) begin
            bus.hash_ready_i = 1'b0;
            bus.hash_val_i   = byte_sum(bus.hash_key_o);
            hcnt = 3;
         end else if (hcnt > 0) begin
            hcnt = hcnt - 1;
            if (hcnt == 0) bus.hash_ready_i = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic [1:0] op, input logic [63:0] key,
                         input logic [31:0] act, input bit hold);
      @(negedge clk);
      chk("ready_before_accept", {63'd0, bus.req_ready_o}, 64'd1);
      bus.req_valid_i  = 1'b1;
      bus.req_op_i     = op;
      bus.req_key_i    = key;
      bus.req_action_i = act;
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid_i = 1'b0;
      r_lat = 0; r_seen = 0; r_rdy_viol = 0; r_starts = 0;
      while (!r_seen && r_lat < 40) begin
         @(negedge clk);
         r_lat++;
         if (bus.req_ready_o) r_rdy_viol++;
         if (bus.hash_start_o) r_starts++;
         if (r_lat == 1) chk("hash_key_at_start", bus.hash_key_o, key);
         if (bus.resp_valid_o) begin
            r_seen   = 1;
            r_status = bus.resp_status_o;
            r_hit    = bus.resp_hit_o;
            r_act    = bus.resp_action_o;
            r_idx    = bus.resp_index_o;
         end
      end
      bus.req_valid_i = 1'b0;
      chk("resp_seen", 64'(r_seen), 64'd1);
      @(negedge clk);
      chk("resp_one_cycle", {63'd0, bus.resp_valid_o}, 64'd0);
   endtask

   task automatic req_chk(input string tag, input logic [1:0] op, input logic [63:0] key,
                          input logic [31:0] act, input int e_lat, input logic [1:0] e_st,
                          input logic e_hit, input logic [31:0] e_act, input logic [7:0] e_idx);
      do_req(op, key, act, 1'b0);
      chk({tag, ".lat"},    64'(r_lat), 64'(e_lat));
      chk({tag, ".status"}, {62'd0, r_status}, {62'd0, e_st});
      chk({tag, ".hit"},    {63'd0, r_hit}, {63'd0, e_hit});
      chk({tag, ".action"}, {32'd0, r_act}, {32'd0, e_act});
      chk({tag, ".index"},  {56'd0, r_idx}, {56'd0, e_idx});
   endtask

   initial begin
      int rv_cnt;
      bus.req_valid_i  = 1'b0;
      bus.req_op_i     = 2'd0;
      bus.req_key_i    = 64'd0;
      bus.req_action_i = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst.req_ready",  {63'd0, bus.req_ready_o}, 64'd1);
      chk("rst.hash_start", {63'd0, bus.hash_start_o}, 64'd0);
      chk("rst.hash_key",   bus.hash_key_o, 64'd0);
      chk("rst.resp_valid", {63'd0, bus.resp_valid_o}, 64'd0);
      chk("rst.resp_index", {56'd0, bus.resp_index_o}, 64'd0);
      rst = 1'b0;

      // empty table: 4 probes from 0x24, not found
      req_chk("lk_empty", 2'd0, 64'h0102030405060708, 32'd0, 13, 2'd1, 1'b0, 32'd0, 8'd0);
      // first insert lands on the home slot after a full scan
      req_chk("ins_1",    2'd1, 64'h1, 32'hAA, 13, 2'd0, 1'b0, 32'd0, 8'd1);
      req_chk("lk_1",     2'd0, 64'h1, 32'd0,   7, 2'd0, 1'b1, 32'hAA, 8'd1);
      req_chk("ins_100",  2'd1, 64'h100, 32'hBB, 13, 2'd0, 1'b0, 32'd0, 8'd2);
      req_chk("lk_100",   2'd0, 64'h100, 32'd0,   9, 2'd0, 1'b1, 32'hBB, 8'd2);
      req_chk("ins_1e4",  2'd1, 64'h10000, 32'h11, 13, 2'd0, 1'b0, 32'd0, 8'd3);
      req_chk("ins_1e6",  2'd1, 64'h1000000, 32'h22, 13, 2'd0, 1'b0, 32'd0, 8'd4);
      req_chk("ins_full", 2'd1, 64'h100000000, 32'h33, 13, 2'd2, 1'b0, 32'd0, 8'd0);
      req_chk("lk_full",  2'd0, 64'h100000000, 32'd0, 13, 2'd1, 1'b0, 32'd0, 8'd0);

      // wrap from 0xFF to 0x00; slots 1..4 already occupied
      req_chk("ins_ff",    2'd1, 64'hFF, 32'h44, 13, 2'd0, 1'b0, 32'd0, 8'hFF);
      req_chk("ins_ff00",  2'd1, 64'hFF00, 32'h55, 13, 2'd0, 1'b0, 32'd0, 8'h00);
      req_chk("lk_ff00",   2'd0, 64'hFF00, 32'd0, 9, 2'd0, 1'b1, 32'h55, 8'h00);
      req_chk("ins_ff_fl", 2'd1, 64'hFF0000, 32'h66, 13, 2'd2, 1'b0, 32'd0, 8'd0);

      // delete, probe across the hole, reuse the hole
      req_chk("del_1",    2'd2, 64'h1, 32'd0, 7, 2'd0, 1'b1, 32'd0, 8'd1);
      req_chk("lk_100b",  2'd0, 64'h100, 32'd0, 9, 2'd0, 1'b1, 32'hBB, 8'd2);
      req_chk("del_miss", 2'd2, 64'h1, 32'd0, 13, 2'd1, 1'b0, 32'd0, 8'd0);
      req_chk("ins_1cc",  2'd1, 64'h1, 32'hCC, 13, 2'd0, 1'b0, 32'd0, 8'd1);
      req_chk("lk_1cc",   2'd0, 64'h1, 32'd0, 7, 2'd0, 1'b1, 32'hCC, 8'd1);
      req_chk("upd_100",  2'd1, 64'h100, 32'hDD, 9, 2'd0, 1'b1, 32'hDD, 8'd2);
      req_chk("op3_lk",   2'd3, 64'h100, 32'd0, 9, 2'd0, 1'b1, 32'hDD, 8'd2);

      // req_valid_i held high for the whole transaction
      do_req(2'd0, 64'h1, 32'd0, 1'b1);
      chk("hold.lat",       64'(r_lat), 64'd7);
      chk("hold.ready_low", 64'(r_rdy_viol), 64'd0);
      chk("hold.starts",    64'(r_starts), 64'd1);
      chk("hold.hit",       {63'd0, r_hit}, 64'd1);
      @(negedge clk);
      chk("hold.no_reaccept", {63'd0, bus.hash_start_o}, 64'd0);

      // reset while waiting for the hash
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = 2'd0;
      bus.req_key_i   = 64'h1;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rv_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.resp_valid_o) rv_cnt++;
      end
      chk("rstwait.no_resp", 64'(rv_cnt), 64'd0);
      chk("rstwait.ready",   {63'd0, bus.req_ready_o}, 64'd1);
      req_chk("rstwait.lk_1", 2'd0, 64'h1, 32'd0, 13, 2'd1, 1'b0, 32'd0, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
